// File: rtl/iicm_pkg.sv
// -----------------------------------------------------------------------------
// iicm_pkg
// Shared definitions for the iicm I2C master and the iicm_arb arbiter that
// shares it between several on-chip clients.
//   state_t : arbiter sequencer states, 3-bit encoding
//   IICM_DW : width of the iicm command word (v_in)
// -----------------------------------------------------------------------------
package iicm_pkg;

  localparam int IICM_DW = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

endpackage

// File: rtl/iicm_arb_if.sv
// -----------------------------------------------------------------------------
// iicm_arb_if
// Bundle between the requesting clients and the iicm_arb arbiter, including
// the command/start pair that the arbiter drives towards the iicm master.
//   req     : request level per requester
//   data    : packed command words, requester i in [DW*i +: DW]
//   gnt     : one-hot grant, held from GRANT through DONE
//   done    : one-hot, single-cycle completion pulse
//   busy    : arbiter is not idle
//   m_v_in  : command word towards iicm.v_in
//   m_start : single-cycle start pulse towards iicm.start_sys
// Modports: master = client side (drives req/data), slave = arbiter side.
// -----------------------------------------------------------------------------
interface iicm_arb_if
  import iicm_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = IICM_DW
);

  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            busy;
  logic [DW-1:0]   m_v_in;
  logic            m_start;

  modport master (
    output req, data,
    input  gnt, done, busy, m_v_in, m_start
  );

  modport slave (
    input  req, data,
    output gnt, done, busy, m_v_in, m_start
  );

endinterface

// File: rtl/iicm_arb_pick.sv
// -----------------------------------------------------------------------------
// iicm_arb_pick
// Combinational rotating-priority picker. The search starts at ptr+1 modulo N
// and returns the first requester found, both one-hot and as a binary index.
// Tying ptr to N-1 turns it into a fixed lowest-index-wins priority encoder.
//   req : request vector
//   ptr : index of the previous winner
//   win : one-hot winner (all zero when req is zero)
//   idx : binary index of the winner (0 when req is zero)
// -----------------------------------------------------------------------------
module iicm_arb_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    // Offsets 1..N visit every requester once, ending on the previous winner,
    // so a held request from the last winner is served only if nobody else asks.
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr) + i) % N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == c) && req[j]) begin
          found  = 1'b1;
          win[j] = 1'b1;
          idx    = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/iicm_arb.sv
// -----------------------------------------------------------------------------
// iicm_arb
// Round-robin arbiter/sequencer sharing one iicm I2C master between N clients.
// A winner is chosen in IDLE, its command word is latched onto m_v_in, a
// single-cycle m_start is issued, the master is held for XFER_CYCLES clocks
// (iicm has no completion output, so completion is timer based), a one-cycle
// done is returned to the winner and GAP_CYCLES idle clocks follow.
//
// Parameters:
//   N           : number of requesters (>= 2)
//   DW          : command word width (iicm v_in width)
//   XFER_CYCLES : clocks reserved per transaction after the start pulse (>= 1)
//   GAP_CYCLES  : idle clocks between done and re-arbitration (may be 0)
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : iicm_arb_if.slave (req, data in; gnt, done, busy, m_v_in, m_start out)
//
// Build option:
//   IICM_ARB_FIXED_PRIO_EN : when defined, lowest index always wins and no
//                            priority pointer register exists.
// -----------------------------------------------------------------------------
module iicm_arb
  import iicm_pkg::*;
#(
  parameter int N           = 4,
  parameter int DW          = IICM_DW,
  parameter int XFER_CYCLES = 180,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  iicm_arb_if.slave  bus
);

  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC0 = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
  localparam int MAXC  = (MAXC0 > 1) ? MAXC0 : 1;
  localparam int CW    = $clog2(MAXC + 1);

  localparam logic [CW-1:0] XFER_LD = CW'(XFER_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   ptr_sel;
  logic [N-1:0]    pick_win;
  logic [IW-1:0]   pick_idx;
  logic [DW-1:0]   sel_data;

  logic [N-1:0]    gnt_q;
  logic [N-1:0]    done_q;
  logic            busy_q;
  logic [DW-1:0]   v_in_q;
  logic            start_q;

`ifdef IICM_ARB_FIXED_PRIO_EN
  // Pointer pinned to the last index makes the search begin at requester 0.
  assign ptr_sel = IW'(N - 1);
`else
  logic [IW-1:0]   ptr;
  assign ptr_sel = ptr;
`endif

  iicm_arb_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req (bus.req),
    .ptr (ptr_sel),
    .win (pick_win),
    .idx (pick_idx)
  );

  // Winner's command slice; only consumed in GRANT.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == IW'(i)) sel_data = bus.data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      win_idx <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      v_in_q  <= '0;
      start_q <= 1'b0;
`ifndef IICM_ARB_FIXED_PRIO_EN
      ptr     <= IW'(N - 1);
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            gnt_q   <= pick_win;
            win_idx <= pick_idx;
            busy_q  <= 1'b1;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          v_in_q <= sel_data;
          state  <= ST_START;
        end
        ST_START: begin
          start_q <= 1'b1;
          cnt     <= XFER_LD;
          state   <= ST_BUSY;
        end
        ST_BUSY: begin
          // The request level is not looked at here: a winner that lets go
          // still gets its full window and its done pulse.
          if (cnt == '0) begin
            done_q <= gnt_q;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: begin
          gnt_q <= '0;
`ifndef IICM_ARB_FIXED_PRIO_EN
          ptr   <= win_idx;
`endif
          if (GAP_CYCLES == 0) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt   <= GAP_LD;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.m_v_in  = v_in_q;
  assign bus.m_start = start_q;

endmodule
